// File: rtl/mig_axi_arbiter.sv
// Two-requester arbiter that funnels single-word CPU accesses onto the
// 128-bit AXI4 slave port of the DDR2 MIG, one transaction at a time.
module mig_axi_arbiter #(
    parameter int ADDR_W = 32,
    parameter int ID_W   = 1
) (
    input  logic              clk_axi,
    input  logic              rstn_axi,

    input  logic              req0,
    input  logic [ADDR_W-1:0] addr0,
    output logic              grant0,
    output logic              done0,
    output logic [31:0]       rdata0,

    input  logic              req1,
    input  logic [3:0]        we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [31:0]       wdata1,
    output logic              grant1,
    output logic              done1,
    output logic [31:0]       rdata1,

    output logic              err,

    output logic [ADDR_W-1:0] m_axi_araddr,
    output logic              m_axi_arvalid,
    input  logic              m_axi_arready,
    output logic [7:0]        m_axi_arlen,
    output logic [2:0]        m_axi_arsize,
    output logic [1:0]        m_axi_arburst,
    output logic              m_axi_arlock,
    output logic [3:0]        m_axi_arcache,
    output logic [2:0]        m_axi_arprot,
    output logic [3:0]        m_axi_arqos,
    output logic [3:0]        m_axi_arregion,
    output logic [ID_W-1:0]   m_axi_arid,

    input  logic [127:0]      m_axi_rdata,
    input  logic [1:0]        m_axi_rresp,
    input  logic              m_axi_rvalid,
    output logic              m_axi_rready,

    output logic [ADDR_W-1:0] m_axi_awaddr,
    output logic              m_axi_awvalid,
    input  logic              m_axi_awready,
    output logic [7:0]        m_axi_awlen,
    output logic [2:0]        m_axi_awsize,
    output logic [1:0]        m_axi_awburst,
    output logic              m_axi_awlock,
    output logic [3:0]        m_axi_awcache,
    output logic [2:0]        m_axi_awprot,
    output logic [3:0]        m_axi_awqos,
    output logic [3:0]        m_axi_awregion,
    output logic [ID_W-1:0]   m_axi_awid,

    output logic [127:0]      m_axi_wdata,
    output logic [15:0]       m_axi_wstrb,
    output logic              m_axi_wvalid,
    output logic              m_axi_wlast,
    input  logic              m_axi_wready,

    input  logic [1:0]        m_axi_bresp,
    input  logic              m_axi_bvalid,
    output logic              m_axi_bready
);

    typedef enum logic [2:0] {IDLE, RD_A, RD_D, WR_AW, WR_B} state_t;

    state_t     state, state_next;
    logic       last_port;
    logic       owner;
    logic [1:0] lane;
    logic       aw_done, w_done;
    logic       win0, win1;
    logic       aw_fin, w_fin;
    logic       r_hs, b_hs;
    logic       arvalid_d, rready_d, awvalid_d, wvalid_d, bready_d;
    logic [31:0] rd_word;
    logic       unused_addr_bits;

    assign m_axi_arlen    = 8'd0;
    assign m_axi_arsize   = 3'b100;
    assign m_axi_arburst  = 2'b01;
    assign m_axi_arlock   = 1'b0;
    assign m_axi_arcache  = 4'b0011;
    assign m_axi_arprot   = 3'd0;
    assign m_axi_arqos    = 4'd0;
    assign m_axi_arregion = 4'd0;
    assign m_axi_arid     = '0;
    assign m_axi_awlen    = 8'd0;
    assign m_axi_awsize   = 3'b100;
    assign m_axi_awburst  = 2'b01;
    assign m_axi_awlock   = 1'b0;
    assign m_axi_awcache  = 4'b0011;
    assign m_axi_awprot   = 3'd0;
    assign m_axi_awqos    = 4'd0;
    assign m_axi_awregion = 4'd0;
    assign m_axi_awid     = '0;
    assign m_axi_wlast    = 1'b1;

    assign unused_addr_bits = ^{addr0[1:0], addr1[1:0]};

    // When both ask, the port that did not win last time goes next.
    assign win1 = req1 & (~req0 | ~last_port);
    assign win0 = req0 & ~win1;

    assign aw_fin  = aw_done | (m_axi_awvalid & m_axi_awready);
    assign w_fin   = w_done  | (m_axi_wvalid  & m_axi_wready);
    assign r_hs    = m_axi_rvalid & m_axi_rready;
    assign b_hs    = m_axi_bvalid & m_axi_bready;
    assign rd_word = m_axi_rdata[{lane, 5'b00000} +: 32];

    always_ff @(posedge clk_axi or negedge rstn_axi) begin
        if (!rstn_axi) state <= IDLE;
        else           state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (win0 || (win1 && we1 == 4'b0000)) state_next = RD_A;
                     else if (win1)                        state_next = WR_AW;
            RD_A:    if (m_axi_arvalid && m_axi_arready)   state_next = RD_D;
            RD_D:    if (r_hs)                             state_next = IDLE;
            WR_AW:   if (aw_fin && w_fin)                  state_next = WR_B;
            WR_B:    if (b_hs)                             state_next = IDLE;
            default:                                       state_next = IDLE;
        endcase
    end

    // Valids are computed one cycle ahead so the AXI outputs come straight from flops.
    always_comb begin
        grant0    = 1'b0;
        grant1    = 1'b0;
        arvalid_d = 1'b0;
        rready_d  = 1'b0;
        awvalid_d = 1'b0;
        wvalid_d  = 1'b0;
        bready_d  = 1'b0;
        if (rstn_axi && state == IDLE) begin
            grant0 = win0;
            grant1 = win1;
        end
        arvalid_d = (state_next == RD_A);
        rready_d  = (state_next == RD_D);
        awvalid_d = (state_next == WR_AW) && !aw_fin;
        wvalid_d  = (state_next == WR_AW) && !w_fin;
        bready_d  = (state_next == WR_B);
    end

    always_ff @(posedge clk_axi or negedge rstn_axi) begin
        if (!rstn_axi) begin
            last_port     <= 1'b1;
            owner         <= 1'b0;
            lane          <= 2'd0;
            aw_done       <= 1'b0;
            w_done        <= 1'b0;
            done0         <= 1'b0;
            done1         <= 1'b0;
            err           <= 1'b0;
            rdata0        <= '0;
            rdata1        <= '0;
            m_axi_araddr  <= '0;
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b0;
            m_axi_awaddr  <= '0;
            m_axi_awvalid <= 1'b0;
            m_axi_wdata   <= '0;
            m_axi_wstrb   <= '0;
            m_axi_wvalid  <= 1'b0;
            m_axi_bready  <= 1'b0;
        end else begin
            m_axi_arvalid <= arvalid_d;
            m_axi_rready  <= rready_d;
            m_axi_awvalid <= awvalid_d;
            m_axi_wvalid  <= wvalid_d;
            m_axi_bready  <= bready_d;
            aw_done       <= (state == WR_AW) && (state_next == WR_AW) && aw_fin;
            w_done        <= (state == WR_AW) && (state_next == WR_AW) && w_fin;
            done0         <= r_hs & ~owner;
            done1         <= (r_hs & owner) | b_hs;
            err           <= (r_hs & (m_axi_rresp != 2'b00)) | (b_hs & (m_axi_bresp != 2'b00));

            if (grant0) begin
                owner        <= 1'b0;
                last_port    <= 1'b0;
                lane         <= addr0[3:2];
                m_axi_araddr <= {addr0[ADDR_W-1:4], 4'b0000};
            end
            // Write data goes out in every lane; only the strobes pick the bytes.
            if (grant1) begin
                owner     <= 1'b1;
                last_port <= 1'b1;
                lane      <= addr1[3:2];
                if (we1 == 4'b0000) begin
                    m_axi_araddr <= {addr1[ADDR_W-1:4], 4'b0000};
                end else begin
                    m_axi_awaddr <= {addr1[ADDR_W-1:4], 4'b0000};
                    m_axi_wdata  <= {4{wdata1}};
                    m_axi_wstrb  <= {12'b0, we1} << {addr1[3:2], 2'b00};
                end
            end

            if (r_hs) begin
                if (owner) rdata1 <= rd_word;
                else       rdata0 <= rd_word;
            end
        end
    end

endmodule

// File: tb/tb_mig_axi_arbiter.sv
// Bench for mig_axi_arbiter: a small MIG slave model with tunable handshake
// delays plus a scoreboard of expected transactions checked at each grant/done.
module tb_mig_axi_arbiter;

    localparam int ADDR_W = 32;
    localparam int ID_W   = 1;

    logic              clk_axi  = 1'b0;
    logic              rstn_axi = 1'b1;
    logic              req0 = 1'b0, req1 = 1'b0;
    logic [ADDR_W-1:0] addr0 = '0, addr1 = '0;
    logic [3:0]        we1 = '0;
    logic [31:0]       wdata1 = '0;
    logic              grant0, done0, grant1, done1, err;
    logic [31:0]       rdata0, rdata1;
    logic [ADDR_W-1:0] m_axi_araddr, m_axi_awaddr;
    logic              m_axi_arvalid, m_axi_rready, m_axi_awvalid, m_axi_wvalid, m_axi_wlast, m_axi_bready;
    logic              m_axi_arready = 1'b0, m_axi_rvalid = 1'b0, m_axi_awready = 1'b0;
    logic              m_axi_wready = 1'b0, m_axi_bvalid = 1'b0;
    logic [127:0]      m_axi_rdata = '0, m_axi_wdata;
    logic [1:0]        m_axi_rresp = '0, m_axi_bresp = '0;
    logic [15:0]       m_axi_wstrb;
    logic [7:0]        m_axi_arlen, m_axi_awlen;
    logic [2:0]        m_axi_arsize, m_axi_awsize, m_axi_arprot, m_axi_awprot;
    logic [1:0]        m_axi_arburst, m_axi_awburst;
    logic              m_axi_arlock, m_axi_awlock;
    logic [3:0]        m_axi_arcache, m_axi_awcache, m_axi_arqos, m_axi_awqos, m_axi_arregion, m_axi_awregion;
    logic [ID_W-1:0]   m_axi_arid, m_axi_awid;

    always #5 clk_axi = ~clk_axi;

    mig_axi_arbiter #(.ADDR_W(ADDR_W), .ID_W(ID_W)) dut (
        .clk_axi(clk_axi), .rstn_axi(rstn_axi),
        .req0(req0), .addr0(addr0), .grant0(grant0), .done0(done0), .rdata0(rdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .grant1(grant1), .done1(done1), .rdata1(rdata1), .err(err),
        .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst),
        .m_axi_arlock(m_axi_arlock), .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot),
        .m_axi_arqos(m_axi_arqos), .m_axi_arregion(m_axi_arregion), .m_axi_arid(m_axi_arid),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rvalid(m_axi_rvalid),
        .m_axi_rready(m_axi_rready),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst),
        .m_axi_awlock(m_axi_awlock), .m_axi_awcache(m_axi_awcache), .m_axi_awprot(m_axi_awprot),
        .m_axi_awqos(m_axi_awqos), .m_axi_awregion(m_axi_awregion), .m_axi_awid(m_axi_awid),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid),
        .m_axi_wlast(m_axi_wlast), .m_axi_wready(m_axi_wready),
        .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready)
    );

    typedef struct {
        bit          port;
        bit          rd;
        logic [31:0] axaddr;
        logic [15:0] strb;
        logic [127:0] wdata;
        logic [31:0] rdata;
        bit          err;
    } exp_t;

    exp_t        exp_q[$];
    logic [127:0] slv_mem [0:63];
    logic [31:0] ref_mem [0:255];

    int check_cnt = 0, error_cnt = 0;
    int cycle = 0, grant_cycle = 0, done_cnt = 0, wfire_cnt = 0, stray_err = 0;
    bit wv_drop_seen = 0;

    int ar_delay = 0, r_delay = 0, aw_delay = 0, w_delay = 0, b_delay = 0;
    logic [1:0] rresp_force = 2'b00, bresp_force = 2'b00;
    int ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt;
    bit ar_fire, r_fire, aw_fire, w_fire, b_fire, rd_pend, aw_got, w_got;
    logic [31:0]  rd_addr, wr_addr;
    logic [127:0] wr_data;
    logic [15:0]  wr_strb;

    task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] want);
        check_cnt++;
        if (got !== want) begin
            error_cnt++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, want);
        end
    endtask

    function automatic logic [31:0] initWord(input int w);
        logic [7:0] b;
        b = w[7:0];
        return (w == 18) ? 32'h0000_0012 : {16'h5A5A, b, b};
    endfunction

    // Predict the transaction from the word-level reference memory.
    task automatic pushExp(input bit port, input logic [3:0] we, input logic [31:0] addr, input logic [31:0] wd);
        exp_t e;
        int   widx;
        widx     = int'(addr[9:2]);
        e.port   = port;
        e.rd     = (we == 4'b0000);
        e.axaddr = {addr[31:4], 4'h0};
        e.strb   = '0;
        for (int b = 0; b < 4; b++) if (we[b]) e.strb[int'(addr[3:2]) * 4 + b] = 1'b1;
        e.wdata  = {4{wd}};
        e.rdata  = ref_mem[widx];
        e.err    = e.rd ? (rresp_force != 2'b00) : (bresp_force != 2'b00);
        exp_q.push_back(e);
        for (int b = 0; b < 4; b++) if (we[b]) ref_mem[widx][8*b +: 8] = wd[8*b +: 8];
    endtask

    task automatic waitDrain();
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge clk_axi);
        checkOutput("drain", 128'(exp_q.size()), 128'd0);
        exp_q.delete();
    endtask

    task automatic applyStimulus(input bit port, input logic [3:0] we, input logic [31:0] addr, input logic [31:0] wd);
        bit got;
        pushExp(port, we, addr, wd);
        @(posedge clk_axi); #1;
        if (port) begin req1 = 1'b1; we1 = we; addr1 = addr; wdata1 = wd; end
        else      begin req0 = 1'b1; addr0 = addr; end
        got = 0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk_axi);
            got = port ? grant1 : grant0;
        end
        checkOutput("grant_seen", 128'(got), 128'd1);
        @(posedge clk_axi); #1;
        req0 = 1'b0; req1 = 1'b0;
        addr0 = $urandom; addr1 = $urandom; wdata1 = $urandom; we1 = 4'($urandom);
        waitDrain();
    endtask

    task automatic checkIdleOutputs();
        checkOutput("idle_ctrl", 128'({grant0, done0, grant1, done1, err, m_axi_arvalid, m_axi_rready,
                                       m_axi_awvalid, m_axi_wvalid, m_axi_bready}), 128'd0);
        checkOutput("idle_rdata", 128'({rdata0, rdata1}), 128'd0);
        checkOutput("idle_addr", 128'({m_axi_araddr, m_axi_awaddr}), 128'd0);
        checkOutput("idle_wdata", m_axi_wdata, 128'd0);
        checkOutput("idle_wstrb", 128'(m_axi_wstrb), 128'd0);
    endtask

    // Slave model and scoreboard monitor, evaluated at each falling edge.
    initial begin
        forever begin
            @(negedge clk_axi);
            cycle++;
            if (!rstn_axi) begin
                m_axi_arready = 0; m_axi_rvalid = 0; m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0;
                ar_fire = 0; r_fire = 0; aw_fire = 0; w_fire = 0; b_fire = 0;
                rd_pend = 0; aw_got = 0; w_got = 0;
                ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
                continue;
            end
            if (done0 || done1) begin
                done_cnt++;
                if (exp_q.size() == 0) checkOutput("spurious_done", 128'(1), 128'(0));
                else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    checkOutput("done_port", 128'({done0, done1}), e.port ? 128'(2'b01) : 128'(2'b10));
                    if (e.rd) checkOutput("rdata", 128'(e.port ? rdata1 : rdata0), 128'(e.rdata));
                    checkOutput("err", 128'(err), 128'(e.err));
                    checkOutput("latency_ge3", 128'((cycle - grant_cycle) >= 3), 128'(1));
                end
            end else if (err) stray_err++;
            if (grant0 || grant1) begin
                grant_cycle = cycle;
                if (exp_q.size() == 0) checkOutput("spurious_grant", 128'(1), 128'(0));
                else checkOutput("grant_port", 128'({grant0, grant1}), exp_q[0].port ? 128'(2'b01) : 128'(2'b10));
            end
            if (m_axi_awvalid && !m_axi_wvalid) wv_drop_seen = 1;

            if (r_fire) begin m_axi_rvalid = 0; r_fire = 0; rd_pend = 0; end
            else if (rd_pend && !m_axi_rvalid) begin
                if (r_cnt < r_delay) r_cnt++;
                else begin
                    m_axi_rvalid = 1; m_axi_rdata = slv_mem[rd_addr[9:4]]; m_axi_rresp = rresp_force;
                end
            end
            r_fire = m_axi_rvalid && m_axi_rready;

            if (ar_fire) begin m_axi_arready = 0; ar_fire = 0; end
            else if (m_axi_arvalid) begin
                if (ar_cnt < ar_delay) ar_cnt++; else m_axi_arready = 1;
            end
            ar_fire = m_axi_arready && m_axi_arvalid;
            if (ar_fire) begin
                rd_addr = m_axi_araddr; rd_pend = 1; r_cnt = 0; ar_cnt = 0;
                if (exp_q.size() == 0) checkOutput("spurious_ar", 128'(1), 128'(0));
                else begin
                    checkOutput("araddr", 128'(m_axi_araddr), 128'(exp_q[0].axaddr));
                    checkOutput("ar_is_read", 128'(exp_q[0].rd), 128'(1));
                end
            end

            if (b_fire) begin m_axi_bvalid = 0; b_fire = 0; end
            else if (!m_axi_bvalid && aw_got && w_got) begin
                if (b_cnt < b_delay) b_cnt++;
                else begin
                    for (int b = 0; b < 16; b++)
                        if (wr_strb[b]) slv_mem[wr_addr[9:4]][8*b +: 8] = wr_data[8*b +: 8];
                    m_axi_bvalid = 1; m_axi_bresp = bresp_force; aw_got = 0; w_got = 0; b_cnt = 0;
                end
            end
            b_fire = m_axi_bvalid && m_axi_bready;

            if (w_fire) begin m_axi_wready = 0; w_fire = 0; end
            else if (m_axi_wvalid) begin
                if (w_cnt < w_delay) w_cnt++; else m_axi_wready = 1;
            end
            w_fire = m_axi_wready && m_axi_wvalid;
            if (w_fire) begin
                w_got = 1; wr_data = m_axi_wdata; wr_strb = m_axi_wstrb; w_cnt = 0; wfire_cnt++;
                if (exp_q.size() != 0) begin
                    checkOutput("wdata", m_axi_wdata, exp_q[0].wdata);
                    checkOutput("wstrb", 128'(m_axi_wstrb), 128'(exp_q[0].strb));
                end
            end

            // The slave holds awready until it has seen write data.
            if (aw_fire) begin m_axi_awready = 0; aw_fire = 0; end
            else if (m_axi_awvalid) begin
                if (aw_cnt < aw_delay) aw_cnt++;
                else if (w_got || m_axi_wvalid) m_axi_awready = 1;
            end
            aw_fire = m_axi_awready && m_axi_awvalid;
            if (aw_fire) begin
                aw_got = 1; wr_addr = m_axi_awaddr; aw_cnt = 0;
                if (exp_q.size() == 0) checkOutput("spurious_aw", 128'(1), 128'(0));
                else begin
                    checkOutput("awaddr", 128'(m_axi_awaddr), 128'(exp_q[0].axaddr));
                    checkOutput("aw_is_write", 128'(exp_q[0].rd), 128'(0));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int g, d0, wf0;
        logic [31:0] a;
        bit p;
        for (int w = 0; w < 256; w++) begin
            ref_mem[w] = initWord(w);
            slv_mem[w / 4][32*(w % 4) +: 32] = initWord(w);
        end
        req0 = 1'b1; addr0 = 32'h48;
        #1 rstn_axi = 1'b0;
        #1;
        checkIdleOutputs();
        checkOutput("ar_consts", 128'({m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arlock, m_axi_arcache,
                                      m_axi_arprot, m_axi_arqos, m_axi_arregion, m_axi_arid}),
                    128'({8'd0, 3'b100, 2'b01, 1'b0, 4'b0011, 3'd0, 4'd0, 4'd0, 1'b0}));
        checkOutput("aw_consts", 128'({m_axi_awlen, m_axi_awsize, m_axi_awburst, m_axi_awlock, m_axi_awcache,
                                      m_axi_awprot, m_axi_awqos, m_axi_awregion, m_axi_awid, m_axi_wlast}),
                    128'({8'd0, 3'b100, 2'b01, 1'b0, 4'b0011, 3'd0, 4'd0, 4'd0, 1'b0, 1'b1}));
        req0 = 1'b0;
        repeat (2) @(posedge clk_axi);
        #1 rstn_axi = 1'b1;
        $display("[TB] reset released");

        // Both ports requesting continuously: grants must alternate starting at port 0.
        for (int k = 0; k < 6; k++) pushExp(k[0], 4'b0000, k[0] ? 32'h24 : 32'h48, 32'h0);
        @(posedge clk_axi); #1;
        req0 = 1'b1; addr0 = 32'h48; req1 = 1'b1; we1 = 4'b0000; addr1 = 32'h24;
        g = 0;
        for (int i = 0; i < 400 && g < 6; i++) begin
            @(negedge clk_axi);
            if (grant0 || grant1) g++;
        end
        @(posedge clk_axi); #1;
        req0 = 1'b0; req1 = 1'b0;
        checkOutput("alt_grants", 128'(g), 128'(6));
        waitDrain();

        $display("[TB] basic read / write / readback");
        applyStimulus(1'b0, 4'b0000, 32'h0000_0048, 32'h0);
        applyStimulus(1'b1, 4'b0011, 32'h0000_001C, 32'hDEAD_BEEF);
        applyStimulus(1'b1, 4'b0000, 32'h0000_001C, 32'h0);
        checkOutput("readback_1c", 128'(rdata1), 128'(32'h5A5A_BEEF));

        $display("[TB] awready delayed after wready");
        aw_delay = 6; wv_drop_seen = 0; d0 = done_cnt; wf0 = wfire_cnt;
        applyStimulus(1'b1, 4'b1100, 32'h0000_0028, 32'hCAFE_F00D);
        checkOutput("wvalid_dropped_first", 128'(wv_drop_seen), 128'(1));
        checkOutput("one_done_for_write", 128'(done_cnt - d0), 128'(1));
        checkOutput("one_w_beat", 128'(wfire_cnt - wf0), 128'(1));
        aw_delay = 0;
        applyStimulus(1'b0, 4'b0000, 32'h0000_0028, 32'h0);
        checkOutput("readback_28", 128'(rdata0), 128'(32'hCAFE_0A0A));

        $display("[TB] read with error response");
        rresp_force = 2'b10;
        applyStimulus(1'b1, 4'b0000, 32'h0000_0030, 32'h0);
        rresp_force = 2'b00;

        $display("[TB] randomized traffic");
        for (int k = 0; k < 8; k++) begin
            ar_delay = $urandom_range(0, 3); r_delay = $urandom_range(0, 3);
            aw_delay = $urandom_range(0, 3); w_delay = $urandom_range(0, 3); b_delay = $urandom_range(0, 3);
            p = 1'($urandom_range(0, 1));
            a = 32'($urandom_range(0, 255)) << 2;
            applyStimulus(p, p ? 4'($urandom_range(0, 15)) : 4'b0000, a, $urandom);
        end
        ar_delay = 0; r_delay = 0; aw_delay = 0; w_delay = 0; b_delay = 0;

        $display("[TB] reset during read data phase");
        r_delay = 30;
        pushExp(1'b0, 4'b0000, 32'h0000_004C, 32'h0);
        @(posedge clk_axi); #1;
        req0 = 1'b1; addr0 = 32'h4C;
        for (int i = 0; i < 20 && !m_axi_rready; i++) begin
            @(negedge clk_axi);
            if (grant0) begin @(posedge clk_axi); #1; req0 = 1'b0; end
        end
        req0 = 1'b0;
        checkOutput("rd_d_reached", 128'(m_axi_rready), 128'(1));
        @(posedge clk_axi); #1;
        rstn_axi = 1'b0;
        #1;
        checkIdleOutputs();
        exp_q.delete();
        d0 = done_cnt;
        repeat (3) @(posedge clk_axi);
        #1 rstn_axi = 1'b1;
        r_delay = 0;
        applyStimulus(1'b0, 4'b0000, 32'h0000_0044, 32'h0);
        checkOutput("done_after_reset", 128'(done_cnt - d0), 128'(1));
        checkOutput("stray_err", 128'(stray_err), 128'(0));

        $display("Simulation finished: %0d checks, %0d errors", check_cnt, error_cnt);
        $finish;
    end

endmodule

// File: doc/mig_axi_arbiter.md
Name: mig_axi_arbiter

Overview:
- Two-requester arbiter/sequencer that shares the single AXI4 slave port of the DDR2 MIG block.
- Requester 0 (instruction fetch) is read-only; requester 1 (data) is read/write.
- Each accepted request becomes exactly one single-beat AXI transaction on the 128-bit bus. The block steers the 32-bit word into its 128-bit lane and selects the returned lane.
- Sits between the CPU memory stage and MIG_BLOCK, clocked in the AXI domain.

Parameters:
- ADDR_W, 32, requester/AXI address width
- ID_W, 1, AXI ID width (id always driven 0)

Ports:
- clk_axi  in  1  AXI-domain clock
- rstn_axi  in  1  reset; asynchronous and active-low
- req0  in  1  requester 0 read request (level)
- addr0  in  ADDR_W  requester 0 byte address
- grant0  out  1  one-cycle pulse: req0 captured
- done0  out  1  one-cycle pulse: read data valid
- rdata0  out  32  requester 0 read word
- req1  in  1  requester 1 request (level)
- we1  in  4  requester 1 byte strobes; 0 = read
- addr1  in  ADDR_W  requester 1 byte address
- wdata1  in  32  requester 1 write word
- grant1  out  1  one-cycle pulse: req1 captured
- done1  out  1  one-cycle pulse: transaction complete
- rdata1  out  32  requester 1 read word
- err  out  1  one-cycle pulse with done*, set if resp != OKAY
- m_axi_araddr/arvalid  out  ADDR_W/1  read address channel
- m_axi_arready  in  1  read address accept
- m_axi_rdata  in  128  read data
- m_axi_rresp  in  2  read response
- m_axi_rvalid  in  1  read data valid
- m_axi_rready  out  1  read data accept
- m_axi_awaddr/awvalid  out  ADDR_W/1  write address channel
- m_axi_awready  in  1  write address accept
- m_axi_wdata/wstrb  out  128/16  write data and strobes
- m_axi_wvalid/wlast  out  1/1  write valid; wlast tied 1
- m_axi_wready  in  1  write data accept
- m_axi_bresp  in  2  write response
- m_axi_bvalid  in  1  write response valid
- m_axi_bready  out  1  write response accept
- m_axi_{ar,aw}{len,size,burst,lock,cache,prot,qos,region,id}  out  various  constants: len 0, size 3'b100, burst 2'b01, cache 4'b0011, all others 0

Behaviour:
- Reset (async, rstn_axi low): FSM to IDLE. All valid/ready/grant/done/err outputs 0. Addr/data/rdata outputs 0. Round-robin pointer last=1, so port 0 wins first.
- Reset mid-transaction abandons it: no done is issued and valids drop immediately. The MIG is reset by the same system reset.
- States:
  - IDLE: arbitrate.
  - RD_A: arvalid=1 until arready.
  - RD_D: rready=1 until rvalid.
  - WR_AW: awvalid and wvalid held; each drops independently after its own handshake; leave when both are done.
  - WR_B: bready=1 until bvalid.
- Arbitration (IDLE only):
  - One requester active: it wins.
  - Both active: the port not granted last wins.
  - Winner gets grant pulse in the same cycle. addr/we/wdata are registered that cycle; the requester may change its inputs after grant.
  - Next state is RD_A if (port0 or we1==0), else WR_AW. The winner is updated in the pointer.
- The AXI address is driven as {addr[ADDR_W-1:4], 4'b0000}. lane = addr[3:2].
- Write data: wdata = wdata1 replicated in all 4 lanes; wstrb = we1 << (4*lane). Lane masking is done by strobes only.
- Read data: the returned word = m_axi_rdata[32*lane +: 32], captured on the rvalid&rready cycle.
- Completion: done<p> and rdata<p> (reads only) asserted the cycle after the R or B handshake, then return to IDLE.
  - rdata<p> holds until the next read on that port.
  - err = (resp != 2'b00) in the same cycle as done.
- Minimum spacing: the next grant is possible in the same cycle done pulses (IDLE reached).
- Back-to-back requests from one port with the other idle are allowed; no starvation, since alternation is forced when both assert.
- AW/W simultaneity: awready and wready arriving in the same or different cycles are both legal.
  - The slave may withhold awready until wvalid, so wvalid must never wait for awready.
- All AXI outputs are registered; no combinational path from any ready input to a valid output.
- Exactly one transaction is outstanding at any time.

Test Plan:
- Read port0, addr0=0x0000_0048, MIG preloaded word 0x12 at index 0x12 -> araddr=0x40, lane 2 selected; done0 with rdata0=mem[0x12]; grant0 3+ cycles before done0.
- Write port1 we1=4'b0011 wdata1=0xDEADBEEF addr1=0x1C -> awaddr=0x10, wstrb=16'h3000. A later read of 0x1C returns the low half as 0xBEEF, upper bytes unchanged; done1, err=0.
- req0 and req1 asserted together for 6 transactions -> grants alternate 0,1,0,1,…, port 0 first after reset.
- Slave delays awready 5 cycles after wready -> wvalid drops after its handshake, awvalid holds; single write lands; exactly one done1.
- Force rresp=2'b10 on a port1 read -> done1 and err pulse together in the same cycle.
- Assert rstn_axi low during RD_D -> all outputs 0 immediately. After release, a new req0 is granted and completes correctly with no spurious done.
